// File: rtl/mem_arbiter_if.sv
// Client-side bundle of the SRAM arbiter: IF fetch port and MEM load/store port.
interface mem_arbiter_if #(
   parameter int AW = 18,
   parameter int DW = 16
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_done;
   logic [DW-1:0] if_rdata;
   logic          if_stall;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_done;
   logic [DW-1:0] mem_rdata;

   modport master (
      output if_req, if_addr,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  if_done, if_rdata, if_stall,
      input  mem_done, mem_rdata
   );

   modport slave (
      input  if_req, if_addr,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output if_done, if_rdata, if_stall,
      output mem_done, mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter for IF and MEM, MEM has priority, IF never starved.
// MEM_ARB_IFBUF_EN adds a one-entry fetch buffer that skips repeated fetches.
module mem_arbiter #(
   parameter int AW       = 18,
   parameter int DW       = 16,
   parameter int WAIT_CYC = 0
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus,
   output logic [AW-1:0] SramAddr,
   inout  wire  [DW-1:0] SramData,
   output logic          SramOE,
   output logic          SramWE,
   output logic          SramEN
);
   typedef enum logic [1:0] {IDLE, ACCESS, WR_REC} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          own_mem_q, own_mem_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          if_done_q, if_done_d;
   logic          mem_done_q, mem_done_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] mem_rdata_q, mem_rdata_d;
   logic          oe_q, oe_d;
   logic          wen_q, wen_d;
   logic          en_q, en_d;
   logic          drv_q, drv_d;
   logic          fair_q, fair_d;
   logic          mem_ok, if_ok, hit;
`ifdef MEM_ARB_IFBUF_EN
   logic          bv_q, bv_d;
   logic [AW-1:0] ba_q, ba_d;
   logic [DW-1:0] bd_q, bd_d;
`endif

   assign SramAddr     = addr_q;
   assign SramOE       = oe_q;
   assign SramWE       = wen_q;
   assign SramEN       = en_q;
   assign SramData     = drv_q ? wdata_q : {DW{1'bz}};
   assign bus.if_done  = if_done_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.if_stall = bus.if_req & ~if_done_q;
   assign bus.mem_done = mem_done_q;
   assign bus.mem_rdata = mem_rdata_q;

   // Right after a write, a waiting fetch goes before another MEM access.
   assign mem_ok = bus.mem_req & ~mem_done_q & ~(fair_q & bus.if_req);
   assign if_ok  = bus.if_req & ~if_done_q;
`ifdef MEM_ARB_IFBUF_EN
   assign hit = bv_q && (bus.if_addr == ba_q);
`else
   assign hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      own_mem_d   = own_mem_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      oe_d        = oe_q;
      wen_d       = wen_q;
      en_d        = en_q;
      drv_d       = drv_q;
      fair_d      = 1'b0;
`ifdef MEM_ARB_IFBUF_EN
      bv_d        = bv_q;
      ba_d        = ba_q;
      bd_d        = bd_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (mem_ok) begin
               own_mem_d = 1'b1;
               we_d      = bus.mem_we;
               addr_d    = bus.mem_addr;
               wdata_d   = bus.mem_wdata;
               cnt_d     = 4'(WAIT_CYC);
               state_d   = ACCESS;
               en_d      = 1'b0;
               oe_d      = bus.mem_we;
               wen_d     = ~bus.mem_we;
               drv_d     = bus.mem_we;
`ifdef MEM_ARB_IFBUF_EN
               if (bus.mem_we) bv_d = 1'b0;
`endif
            end else if (if_ok && hit) begin
               if_done_d = 1'b1;
`ifdef MEM_ARB_IFBUF_EN
               if_rdata_d = bd_q;
`endif
            end else if (if_ok) begin
               own_mem_d = 1'b0;
               we_d      = 1'b0;
               addr_d    = bus.if_addr;
               cnt_d     = 4'(WAIT_CYC);
               state_d   = ACCESS;
               en_d      = 1'b0;
               oe_d      = 1'b0;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = 4'(cnt_q - 4'd1);
            end else if (we_q) begin
               state_d    = WR_REC;
               wen_d      = 1'b1;
               mem_done_d = 1'b1;
            end else begin
               state_d = IDLE;
               en_d    = 1'b1;
               oe_d    = 1'b1;
               if (own_mem_q) begin
                  mem_rdata_d = SramData;
                  mem_done_d  = 1'b1;
               end else begin
                  if_rdata_d = SramData;
                  if_done_d  = 1'b1;
`ifdef MEM_ARB_IFBUF_EN
                  bv_d = 1'b1;
                  ba_d = addr_q;
                  bd_d = SramData;
`endif
               end
            end
         end
         WR_REC: begin
            state_d = IDLE;
            en_d    = 1'b1;
            drv_d   = 1'b0;
            fair_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         own_mem_q   <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         oe_q        <= 1'b1;
         wen_q       <= 1'b1;
         en_q        <= 1'b1;
         drv_q       <= 1'b0;
         fair_q      <= 1'b0;
`ifdef MEM_ARB_IFBUF_EN
         bv_q        <= 1'b0;
         ba_q        <= '0;
         bd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         own_mem_q   <= own_mem_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         oe_q        <= oe_d;
         wen_q       <= wen_d;
         en_q        <= en_d;
         drv_q       <= drv_d;
         fair_q      <= fair_d;
`ifdef MEM_ARB_IFBUF_EN
         bv_q        <= bv_d;
         ba_q        <= ba_d;
         bd_q        <= bd_d;
`endif
      end
   end
endmodule
